// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI RAM controller.
// Contents: command opcode enum carried in din[ADDR_SIZE+1:ADDR_SIZE], and
// the controller FSM state type.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    OP_SET_WADDR = 2'b00,
    OP_WRITE     = 2'b01,
    OP_SET_RADDR = 2'b10,
    OP_READ      = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_TX   = 2'b10
  } state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Word-addressed storage for the SPI RAM controller.
// One synchronous write port and one synchronous, enable-gated read port.
// A read and a write to the same address on the same edge return the old
// word (read-before-write). The array itself is never reset; only the read
// data register is cleared by rst.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high, clears rdata only
//   we/waddr/wdata write port
//   re/raddr       read port; rdata updates only when re is high
//   rdata          registered read data, holds between reads
module spi_ram_mem #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [ADDR_SIZE-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE-1:0] rdata
);

  logic [ADDR_SIZE-1:0] mem_q [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder and read FSM sitting between an SPI slave and a small RAM.
// Each frame with rx_valid high is one command: 00 set write address,
// 01 write data, 10 set read address, 11 read request. A read request in
// IDLE captures memory[read_addr] on the following edge into dout and raises
// tx_valid, which holds until tx_ready. A read request while a read is
// already in flight is dropped and flagged with a one-cycle cmd_err.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   din, rx_valid     incoming command frame {opcode, payload}
//   tx_ready          SPI slave accepts dout
//   dout, tx_valid    registered read data and its valid flag
//   cmd_err           registered one-cycle pulse on a rejected read request
// Build option: define SPI_RAM_AUTOINC_EN to post-increment write_addr after
// each write and read_addr after each read capture, wrapping at MEM_DEPTH-1.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  input  logic                 tx_ready,
  output logic [ADDR_SIZE-1:0] dout,
  output logic                 tx_valid,
  output logic                 cmd_err
);

  opcode_e              op;
  logic [ADDR_SIZE-1:0] payload;

  state_e               state_d, state_q;
  logic                 tx_valid_d, tx_valid_q;
  logic                 cmd_err_d, cmd_err_q;
  logic [ADDR_SIZE-1:0] waddr_d, waddr_q;
  logic [ADDR_SIZE-1:0] raddr_d, raddr_q;
  logic                 mem_we, mem_re;

  assign op      = opcode_e'(din[ADDR_SIZE+1:ADDR_SIZE]);
  assign payload = din[ADDR_SIZE-1:0];

`ifdef SPI_RAM_AUTOINC_EN
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    cmd_err_d  = 1'b0;
    waddr_d    = waddr_q;
    raddr_d    = raddr_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;

    // FSM progression runs independently of rx_valid.
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && op == OP_READ) state_d = ST_RD;
      end
      ST_RD: begin
        mem_re     = 1'b1;
        tx_valid_d = 1'b1;
        state_d    = ST_TX;
`ifdef SPI_RAM_AUTOINC_EN
        raddr_d    = next_addr(raddr_q);
`endif
      end
      ST_TX: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Address loads come after the auto-increment so an explicit 00/10 in
    // the same cycle wins. The RD capture reads raddr_q, so a 10 arriving
    // on the capture edge only affects the next read.
    if (rx_valid) begin
      case (op)
        OP_SET_WADDR: waddr_d = payload;
        OP_WRITE: begin
          mem_we  = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
          waddr_d = next_addr(waddr_q);
`endif
        end
        OP_SET_RADDR: raddr_d = payload;
        OP_READ:      if (state_q != ST_IDLE) cmd_err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      waddr_q    <= '0;
      raddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
    end
  end

  // dout is the memory's read register: loaded only on the RD edge, held
  // through TX, cleared by rst.
  spi_ram_mem #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we && !rst),
    .waddr (waddr_q),
    .wdata (payload),
    .re    (mem_re),
    .raddr (raddr_q),
    .rdata (dout)
  );

  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
module tb_spi_ram_ctrl;

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .rx_valid (rx_valid),
    .tx_ready (tx_ready),
    .dout     (dout),
    .tx_valid (tx_valid),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: a read request is "pending" for one edge, then the
  // word is captured and presented until handed over.
  logic [7:0] m_mem [256];
  int         m_wa = 0, m_ra = 0;
  bit         m_pend = 0, m_valid = 0, m_err = 0;
  logic [7:0] m_dout = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_wa = 0; m_ra = 0; m_pend = 0; m_valid = 0; m_err = 0; m_dout = '0;
    end else begin
      bit busy;
      busy  = m_pend || m_valid;
      m_err = 0;
      if (m_pend) begin
        m_dout  = m_mem[m_ra];           // captured before any write this edge
        m_valid = 1;
        m_pend  = 0;
        if (AUTOINC) m_ra = (m_ra + 1) % 256;
      end else if (m_valid && tx_ready) begin
        m_valid = 0;
      end
      if (rx_valid) begin
        case (din[9:8])
          2'b00: m_wa = int'(din[7:0]);
          2'b01: begin
            m_mem[m_wa] = din[7:0];
            if (AUTOINC) m_wa = (m_wa + 1) % 256;
          end
          2'b10: m_ra = int'(din[7:0]);
          default: if (busy) m_err = 1; else m_pend = 1;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_tx_valid", {7'd0, tx_valid}, {7'd0, m_valid});
      chk("model_cmd_err",  {7'd0, cmd_err},  {7'd0, m_err});
      if (m_valid) chk("model_dout", dout, m_dout);
    end
  end

  // One clock: drive inputs away from the edge, return 1 time unit after it.
  task automatic step(input logic [1:0] op, input logic [7:0] pl,
                      input bit rxv, input bit txr);
    din      = {op, pl};
    rx_valid = rxv;
    tx_ready = txr;
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
    step(op, pl, 1'b1, 1'b0);
  endtask

  task automatic idle(input bit txr);
    step(2'b00, 8'h00, 1'b0, txr);
  endtask

  initial begin
    rst = 1'b1;
    step(2'b01, 8'hEE, 1'b1, 1'b0);   // write attempt under reset is ignored
    step(2'b11, 8'h00, 1'b1, 1'b0);
    chk("reset_dout", dout, 8'h00);
    chk("reset_tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("reset_cmd_err", {7'd0, cmd_err}, 8'h00);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Basic write then read, latency 2 edges.
    cmd(2'b00, 8'h10);
    cmd(2'b01, 8'hA5);
    cmd(2'b10, 8'h10);
    cmd(2'b11, 8'h00);
    chk("basic_no_valid_at_accept", {7'd0, tx_valid}, 8'h00);
    idle(1'b0);
    chk("basic_tx_valid", {7'd0, tx_valid}, 8'h01);
    chk("basic_dout", dout, 8'hA5);

    // Held with tx_ready low; second read request rejected.
    for (int unsigned i = 0; i < 5; i++) idle(1'b0);
    chk("hold_tx_valid", {7'd0, tx_valid}, 8'h01);
    cmd(2'b11, 8'h00);
    chk("busy_cmd_err", {7'd0, cmd_err}, 8'h01);
    chk("busy_dout", dout, 8'hA5);
    idle(1'b0);
    chk("busy_err_pulse_once", {7'd0, cmd_err}, 8'h00);
    idle(1'b1);
    chk("release_tx_valid", {7'd0, tx_valid}, 8'h00);

    // tx_ready with nothing to send, and an 11 with rx_valid low: no effect.
    idle(1'b1);
    step(2'b11, 8'h00, 1'b0, 1'b1);
    idle(1'b0);
    chk("idle_no_valid", {7'd0, tx_valid}, 8'h00);

    // Read-before-write on the capture edge; also 10 on that edge is ignored.
    cmd(2'b00, 8'h20);
    cmd(2'b01, 8'h11);
    cmd(2'b00, 8'h20);
    cmd(2'b10, 8'h20);
    cmd(2'b11, 8'h00);
    cmd(2'b01, 8'h22);
    chk("rbw_old_data", dout, 8'h11);
    idle(1'b1);
    cmd(2'b10, 8'h20);
    cmd(2'b11, 8'h00);
    cmd(2'b10, 8'h10);                // lands on capture edge: must not redirect
    chk("rbw_new_data", dout, 8'h22);
    idle(1'b1);

`ifdef SPI_RAM_AUTOINC_EN
    cmd(2'b00, 8'hFF);
    cmd(2'b01, 8'h01);
    cmd(2'b01, 8'h02);
    cmd(2'b10, 8'hFF);
    cmd(2'b11, 8'h00);
    idle(1'b0);
    chk("autoinc_first", dout, 8'h01);
    idle(1'b1);
    cmd(2'b11, 8'h00);
    idle(1'b0);
    chk("autoinc_wrap", dout, 8'h02);
    idle(1'b1);
`else
    cmd(2'b00, 8'h06);
    cmd(2'b01, 8'h77);
    cmd(2'b00, 8'h05);
    cmd(2'b01, 8'h33);
    cmd(2'b01, 8'h44);
    cmd(2'b10, 8'h05);
    cmd(2'b11, 8'h00);
    idle(1'b0);
    chk("noinc_overwrite", dout, 8'h44);
    idle(1'b1);
    cmd(2'b10, 8'h06);
    cmd(2'b11, 8'h00);
    idle(1'b0);
    chk("noinc_neighbour", dout, 8'h77);
    idle(1'b1);
`endif

    // Reset during TX aborts the transfer.
    cmd(2'b10, 8'h10);
    cmd(2'b11, 8'h00);
    idle(1'b0);
    chk("pre_reset_valid", {7'd0, tx_valid}, 8'h01);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    chk("tx_reset_valid", {7'd0, tx_valid}, 8'h00);
    chk("tx_reset_dout", dout, 8'h00);
    for (int unsigned i = 0; i < 4; i++) idle(1'b0);
    chk("tx_reset_no_late_valid", {7'd0, tx_valid}, 8'h00);

    // Reset during RD aborts too; read address returns to 0.
    cmd(2'b00, 8'h00);
    cmd(2'b01, 8'h5C);
    cmd(2'b10, 8'h20);
    cmd(2'b11, 8'h00);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    for (int unsigned i = 0; i < 3; i++) idle(1'b0);
    chk("rd_reset_no_valid", {7'd0, tx_valid}, 8'h00);
    cmd(2'b11, 8'h00);
    idle(1'b0);
    chk("post_reset_raddr0", dout, 8'h5C);
    idle(1'b1);
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
